dffram_arbiter2: RTL and testbench

Two-requester round-robin arbiter that shares one single-port DFFRAM (512x32, 4 byte-lane write enables) between two masters, e.g. a CPU data port and a DMA engine.
- Grants at most one access per cycle and drives the RAM port.
- Tracks in-flight reads and returns registered read data with a valid pulse to the requester that issued the read.
- Sits directly in front of the DFFRAM macro; the macro is unmodified.

---
 rtl/dffram_arb_pkg.sv | 24 ++
 rtl/dffram_rd_return.sv | 67 ++++++
 rtl/dffram_arbiter2.sv | 114 +++++++++++
 tb/tb_dffram_arbiter2.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_arb_pkg.sv
// Shared definitions for the two-port DFFRAM arbiter: geometry defaults,
// port-ID constants and the saturating statistics counter helper.
// No logic of its own; latency and backpressure are defined by the users.
package dffram_arb_pkg;

   localparam int AW_DEF    = 9;
   localparam int DW_DEF    = 32;
   localparam int WSIZE_DEF = DW_DEF / 8;

   // Port identifiers, also used as the value of the round-robin pointer.
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Statistics counters (only used when DFFRAM_ARB_STATS_EN is defined).
   localparam int                STAT_W   = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   // Increment by one when en is set, sticking at STAT_MAX instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                 input logic              en);
      return (en && (v != STAT_MAX)) ? v + 1'b1 : v;
   endfunction

endpackage

// File: rtl/dffram_rd_return.sv
// Read-return pipeline: remembers which port issued a read and delivers RAM data to it.
// Latency: read granted in cycle N -> do/rvalid for that port in cycle N+2.
// No backpressure: one read per cycle accepted, each return is a single-cycle pulse.
//
// Ports:
//   CLK, RESETn          clock, async active-low reset
//   rd_fire_i            a read is granted this cycle
//   rd_port_i            port ID of that read
//   ram_do_i             RAM read data (valid the cycle after the grant)
//   rvalid0_o/rvalid1_o  one-cycle return pulse per port
//   do0_o/do1_o          registered read data per port, held between returns
module dffram_rd_return
   import dffram_arb_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          rd_fire_i,
   input  logic          rd_port_i,
   input  logic [DW-1:0] ram_do_i,
   output logic          rvalid0_o,
   output logic          rvalid1_o,
   output logic [DW-1:0] do0_o,
   output logic [DW-1:0] do1_o
);

   // Stage 1: read issued last edge, RAM_DO valid in this cycle.
   logic          rd1_q, rd1_d;
   logic          id_q, id_d;
   // Stage 2: captured data and return pulse.
   logic          rv0_q, rv0_d, rv1_q, rv1_d;
   logic [DW-1:0] do0_q, do0_d, do1_q, do1_d;

   always_comb begin
      rd1_d = rd_fire_i;
      id_d  = rd_port_i;
      rv0_d = rd1_q && (id_q == PORT0);
      rv1_d = rd1_q && (id_q == PORT1);
      do0_d = rv0_d ? ram_do_i : do0_q;
      do1_d = rv1_d ? ram_do_i : do1_q;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         rd1_q <= 1'b0;
         id_q  <= PORT0;
         rv0_q <= 1'b0;
         rv1_q <= 1'b0;
         do0_q <= '0;
         do1_q <= '0;
      end else begin
         rd1_q <= rd1_d;
         id_q  <= id_d;
         rv0_q <= rv0_d;
         rv1_q <= rv1_d;
         do0_q <= do0_d;
         do1_q <= do1_d;
      end
   end

   assign rvalid0_o = rv0_q;
   assign rvalid1_o = rv1_q;
   assign do0_o     = do0_q;
   assign do1_o     = do1_q;

endmodule

// File: rtl/dffram_arbiter2.sv
// Two-port round-robin arbiter in front of a single-port 512x32 DFFRAM macro.
// Latency: grant is combinational; writes complete at the grant edge, reads return 2 cycles later.
// Backpressure: a requester holds REQx/WEx/Ax/DIx until GNTx; reads are never stalled once granted.
//
// Ports: CLK/RESETn; per port x: REQx, WEx (all-zero = read), Ax, DIx in;
//        GNTx, RVALIDx, DOx out. RAM side: RAM_EN/RAM_WE/RAM_A/RAM_DI out, RAM_DO in.
// Optional build macro DFFRAM_ARB_STATS_EN adds saturating counters GCNT0, GCNT1
// (grants per port) and CCNT (cycles with both ports requesting).
module dffram_arbiter2
   import dffram_arb_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int WSIZE = WSIZE_DEF
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             REQ0,
   input  logic [WSIZE-1:0] WE0,
   input  logic [AW-1:0]    A0,
   input  logic [DW-1:0]    DI0,
   input  logic             REQ1,
   input  logic [WSIZE-1:0] WE1,
   input  logic [AW-1:0]    A1,
   input  logic [DW-1:0]    DI1,
   output logic             GNT0,
   output logic             GNT1,
   output logic             RVALID0,
   output logic             RVALID1,
   output logic [DW-1:0]    DO0,
   output logic [DW-1:0]    DO1,
   output logic             RAM_EN,
   output logic [WSIZE-1:0] RAM_WE,
   output logic [AW-1:0]    RAM_A,
   output logic [DW-1:0]    RAM_DI,
   input  logic [DW-1:0]    RAM_DO
`ifdef DFFRAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] GCNT0,
   output logic [STAT_W-1:0] GCNT1,
   output logic [STAT_W-1:0] CCNT
`endif
);

   // Port that won most recently; resets to PORT1 so port 0 wins first contention.
   logic last_q, last_d;
   logic gnt0, gnt1;
   logic rd_fire;

   always_comb begin
      gnt0    = REQ0 && (!REQ1 || (last_q == PORT1));
      gnt1    = REQ1 && (!REQ0 || (last_q == PORT0));
      last_d  = gnt0 ? PORT0 : (gnt1 ? PORT1 : last_q);
      rd_fire = (gnt0 && (WE0 == '0)) || (gnt1 && (WE1 == '0));
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) last_q <= PORT1;
      else         last_q <= last_d;
   end

   assign GNT0 = gnt0;
   assign GNT1 = gnt1;

   // RAM port mux; everything held at zero when idle.
   always_comb begin
      RAM_EN = gnt0 || gnt1;
      RAM_WE = '0;
      RAM_A  = '0;
      RAM_DI = '0;
      if (gnt0) begin
         RAM_WE = WE0;
         RAM_A  = A0;
         RAM_DI = DI0;
      end else if (gnt1) begin
         RAM_WE = WE1;
         RAM_A  = A1;
         RAM_DI = DI1;
      end
   end

   dffram_rd_return #(.DW(DW)) u_rd_return (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .rd_fire_i (rd_fire),
      .rd_port_i (gnt1),
      .ram_do_i  (RAM_DO),
      .rvalid0_o (RVALID0),
      .rvalid1_o (RVALID1),
      .do0_o     (DO0),
      .do1_o     (DO1)
   );

`ifdef DFFRAM_ARB_STATS_EN
   logic [STAT_W-1:0] gcnt0_q, gcnt1_q, ccnt_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
         ccnt_q  <= '0;
      end else begin
         gcnt0_q <= sat_inc(gcnt0_q, gnt0);
         gcnt1_q <= sat_inc(gcnt1_q, gnt1);
         ccnt_q  <= sat_inc(ccnt_q, REQ0 && REQ1);
      end
   end

   assign GCNT0 = gcnt0_q;
   assign GCNT1 = gcnt1_q;
   assign CCNT  = ccnt_q;
`endif

endmodule

// File: tb/tb_dffram_arbiter2.sv
// Bench for dffram_arbiter2: behavioural DFFRAM plus a transaction-level reference
// (grant rule, shadow memory, queue of pending read returns with due cycles).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dffram_arbiter2;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int WS = 4;

   logic          CLK = 1'b0;
   logic          RESETn;
   logic          REQ0, REQ1;
   logic [WS-1:0] WE0, WE1;
   logic [AW-1:0] A0, A1;
   logic [DW-1:0] DI0, DI1;
   logic          GNT0, GNT1, RVALID0, RVALID1;
   logic [DW-1:0] DO0, DO1;
   logic          RAM_EN;
   logic [WS-1:0] RAM_WE;
   logic [AW-1:0] RAM_A;
   logic [DW-1:0] RAM_DI;
   logic [DW-1:0] RAM_DO;
`ifdef DFFRAM_ARB_STATS_EN
   logic [15:0]   GCNT0, GCNT1, CCNT;
`endif

   always #5 CLK = ~CLK;

   dffram_arbiter2 dut (
      .CLK(CLK), .RESETn(RESETn),
      .REQ0(REQ0), .WE0(WE0), .A0(A0), .DI0(DI0),
      .REQ1(REQ1), .WE1(WE1), .A1(A1), .DI1(DI1),
      .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
      .DO0(DO0), .DO1(DO1),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
`ifdef DFFRAM_ARB_STATS_EN
      , .GCNT0(GCNT0), .GCNT1(GCNT1), .CCNT(CCNT)
`endif
   );

   // Behavioural DFFRAM macro: synchronous read and byte-lane write.
   logic [DW-1:0] ram [0:511];
   always @(posedge CLK) begin
      if (RAM_EN) begin
         if (RAM_WE == '0) RAM_DO <= ram[RAM_A];
         else for (int i = 0; i < WS; i++)
            if (RAM_WE[i]) ram[RAM_A][8*i +: 8] <= RAM_DI[8*i +: 8];
      end
   end

   int tests = 0;
   int fails = 0;

   // ---------------- reference model ----------------
   typedef struct { int port; logic [DW-1:0] data; int due; } rd_t;
   logic [DW-1:0] mem_m [0:511];
   rd_t           pend [$];
   int            last_m, cyc, mg;
   logic          exp_rv0, exp_rv1;
   logic [DW-1:0] exp_do0, exp_do1;

   function automatic int pick(input logic r0, input logic r1, input int last);
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      if (r0 && r1)  return (last == 0) ? 1 : 0;
      return -1;
   endfunction

   task automatic model_reset();
      last_m = 1; pend.delete(); mg = -1;
      exp_rv0 = 0; exp_rv1 = 0; exp_do0 = '0; exp_do1 = '0;
   endtask

   task automatic model_step();
      int p; logic [WS-1:0] we; logic [AW-1:0] a; logic [DW-1:0] d; rd_t e;
      p = pick(REQ0, REQ1, last_m);
      exp_rv0 = 0; exp_rv1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
         e = pend.pop_front();
         if (e.port == 0) begin exp_rv0 = 1; exp_do0 = e.data; end
         else             begin exp_rv1 = 1; exp_do1 = e.data; end
      end
      if (p >= 0) begin
         we = (p == 0) ? WE0 : WE1;
         a  = (p == 0) ? A0  : A1;
         d  = (p == 0) ? DI0 : DI1;
         if (we == '0) begin
            e.port = p; e.data = mem_m[a]; e.due = cyc + 2;
            pend.push_back(e);
         end else begin
            for (int i = 0; i < WS; i++) if (we[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
         end
         last_m = p;
      end
      mg = p;
      cyc++;
   endtask

   task automatic clk_edge();
      @(posedge CLK);
      if (RESETn) model_step();
      #1;
   endtask

   task automatic drive(input logic r0, input logic [WS-1:0] w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic r1, input logic [WS-1:0] w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      REQ0 = r0; WE0 = w0; A0 = a0; DI0 = d0;
      REQ1 = r1; WE1 = w1; A1 = a1; DI1 = d1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      idle();
      RESETn = 1'b0;
      model_reset();
      clk_edge(); clk_edge();
      RESETn = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      tests++; if ({RVALID0, RVALID1} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b want 00", {RVALID0, RVALID1}); end
      tests++; if (DO0 !== '0 || DO1 !== '0) begin fails++; $display("FAIL reset_do got %h/%h want 0/0", DO0, DO1); end
      tests++; if ({GNT0, GNT1, RAM_EN} !== 3'b000) begin fails++; $display("FAIL reset_idle_gnt got %b want 000", {GNT0, GNT1, RAM_EN}); end
      tests++; if (RAM_WE !== '0 || RAM_A !== '0 || RAM_DI !== '0) begin fails++; $display("FAIL idle_ram_bus got %h %h %h want 0", RAM_WE, RAM_A, RAM_DI); end
      clk_edge();
   endtask

   task automatic test_write_read();
      drive(1, 4'hF, 9'h010, 32'hDEADBEEF, 0, 0, 0, 0);
      @(negedge CLK);
      tests++; if ({GNT0, GNT1} !== 2'b10) begin fails++; $display("FAIL wr_gnt got %b want 10", {GNT0, GNT1}); end
      tests++; if (RAM_WE !== 4'hF || RAM_A !== 9'h010 || RAM_DI !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_ram_bus got %h %h %h", RAM_WE, RAM_A, RAM_DI); end
      clk_edge();
      drive(1, 4'h0, 9'h010, 32'h0, 0, 0, 0, 0);
      @(negedge CLK);
      tests++; if (GNT0 !== 1'b1) begin fails++; $display("FAIL rd_gnt got %b want 1", GNT0); end
      clk_edge();
      idle();
      @(negedge CLK);
      tests++; if (RVALID0 !== 1'b0) begin fails++; $display("FAIL rd_early_rvalid got %b want 0", RVALID0); end
      clk_edge();
      @(negedge CLK);
      tests++; if (RVALID0 !== 1'b1 || DO0 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_return got %b %h want 1 deadbeef", RVALID0, DO0); end
      tests++; if (RVALID1 !== 1'b0) begin fails++; $display("FAIL rd_wrong_port got %b want 0", RVALID1); end
      clk_edge();
      @(negedge CLK);
      tests++; if (RVALID0 !== 1'b0 || DO0 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold got %b %h want 0 deadbeef", RVALID0, DO0); end
      clk_edge();
   endtask

   task automatic test_contention();
      int order [4] = '{0, 1, 0, 1};
      int n = 0, c0 = 0, c1 = 0, r0 = 0, r1 = 0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (n < 4) drive(1, 0, 9'(9'h020 + c0), 0, 1, 0, 9'(9'h030 + c1), 0);
         else idle();
         @(negedge CLK);
         if (n < 4) begin
            tests++;
            if ({GNT0, GNT1} !== ((order[n] == 0) ? 2'b10 : 2'b01)) begin
               fails++; $display("FAIL contention_order grant %0d got %b want port %0d", n, {GNT0, GNT1}, order[n]);
            end
         end
         tests++;
         if (RVALID0 !== exp_rv0 || RVALID1 !== exp_rv1 || (exp_rv0 && DO0 !== exp_do0) || (exp_rv1 && DO1 !== exp_do1)) begin
            fails++; $display("FAIL contention_return cyc %0d got %b%b %h %h want %b%b %h %h", k, RVALID0, RVALID1, DO0, DO1, exp_rv0, exp_rv1, exp_do0, exp_do1);
         end
         r0 += int'(RVALID0); r1 += int'(RVALID1);
         if (n < 4) begin
            if (GNT0) c0++;
            if (GNT1) c1++;
            n++;
         end
         clk_edge();
      end
      tests++; if (r0 != 2 || r1 != 2) begin fails++; $display("FAIL contention_counts got %0d/%0d want 2/2", r0, r1); end
   endtask

   task automatic test_byte_lanes();
      drive(1, 4'hF, 9'h1FF, 32'h11223344, 0, 0, 0, 0); clk_edge();
      drive(1, 4'b0101, 9'h1FF, 32'hAABBCCDD, 0, 0, 0, 0); clk_edge();
      drive(1, 4'h0, 9'h1FF, 0, 0, 0, 0, 0); clk_edge();
      idle(); clk_edge();
      @(negedge CLK);
      tests++; if (RVALID0 !== 1'b1 || DO0 !== 32'h11BB33DD) begin fails++; $display("FAIL byte_lanes got %b %h want 1 11bb33dd", RVALID0, DO0); end
      clk_edge();
   endtask

   task automatic test_pipelined();
      drive(0, 0, 0, 0, 1, 4'hF, 9'd5, 32'h55550005); clk_edge();
      drive(0, 0, 0, 0, 1, 4'hF, 9'd6, 32'h66660006); clk_edge();
      drive(1, 0, 9'd5, 0, 0, 0, 0, 0);
      @(negedge CLK);
      tests++; if (GNT0 !== 1'b1) begin fails++; $display("FAIL pipe_gnt0 got %b want 1", GNT0); end
      clk_edge();
      drive(0, 0, 0, 0, 1, 0, 9'd6, 0);
      @(negedge CLK);
      tests++; if (GNT1 !== 1'b1) begin fails++; $display("FAIL pipe_gnt1 got %b want 1", GNT1); end
      clk_edge();
      idle();
      @(negedge CLK);
      tests++; if (RVALID0 !== 1'b1 || DO0 !== 32'h55550005 || RVALID1 !== 1'b0) begin fails++; $display("FAIL pipe_ret0 got %b %h %b", RVALID0, DO0, RVALID1); end
      clk_edge();
      @(negedge CLK);
      tests++; if (RVALID1 !== 1'b1 || DO1 !== 32'h66660006 || RVALID0 !== 1'b0 || DO0 !== 32'h55550005) begin fails++; $display("FAIL pipe_ret1 got %b %h %b %h", RVALID1, DO1, RVALID0, DO0); end
      clk_edge();
   endtask

   task automatic test_reset_mid_read();
      int seen = 0;
      drive(1, 0, 9'd5, 0, 0, 0, 0, 0);
      @(negedge CLK);
      tests++; if (GNT0 !== 1'b1) begin fails++; $display("FAIL rst_rd_gnt got %b want 1", GNT0); end
      clk_edge();
      idle();
      RESETn = 1'b0;
      model_reset();
      clk_edge(); clk_edge();
      RESETn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         seen += int'(RVALID0 || RVALID1);
         tests++; if (DO0 !== '0 || DO1 !== '0) begin fails++; $display("FAIL rst_do cyc %0d got %h/%h want 0/0", k, DO0, DO1); end
         clk_edge();
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL rst_dropped_read got %0d rvalids want 0", seen); end
      drive(1, 0, 9'd1, 0, 1, 0, 9'd2, 0);
      @(negedge CLK);
      tests++; if ({GNT0, GNT1} !== 2'b10) begin fails++; $display("FAIL rst_first_contention got %b want 10", {GNT0, GNT1}); end
      clk_edge();
      idle(); clk_edge(); clk_edge(); clk_edge();
   endtask

   task automatic test_random();
      logic hold0 = 0, hold1 = 0;
      int p; logic [AW-1:0] ea;
      for (int c = 0; c < 400; c++) begin
         if (!hold0) begin
            REQ0 = ($urandom_range(0, 99) < 60);
            WE0  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            A0   = $urandom_range(0, 7) == 0 ? 9'($urandom_range(504, 511)) : 9'($urandom_range(0, 7));
            DI0  = $urandom;
         end
         if (!hold1) begin
            REQ1 = ($urandom_range(0, 99) < 60);
            WE1  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            A1   = $urandom_range(0, 7) == 0 ? 9'($urandom_range(504, 511)) : 9'($urandom_range(0, 7));
            DI1  = $urandom;
         end
         @(negedge CLK);
         p  = pick(REQ0, REQ1, last_m);
         ea = (p == 0) ? A0 : ((p == 1) ? A1 : 9'd0);
         tests++;
         if ({GNT0, GNT1} !== {p == 0, p == 1} || RAM_EN !== (p >= 0) || RAM_A !== ea) begin
            fails++; $display("FAIL rand_grant cyc %0d got %b%b en=%b a=%h want port %0d a=%h", c, GNT0, GNT1, RAM_EN, RAM_A, p, ea);
         end
         tests++;
         if (RVALID0 !== exp_rv0 || RVALID1 !== exp_rv1 || DO0 !== exp_do0 || DO1 !== exp_do1) begin
            fails++; $display("FAIL rand_return cyc %0d got %b%b %h %h want %b%b %h %h", c, RVALID0, RVALID1, DO0, DO1, exp_rv0, exp_rv1, exp_do0, exp_do1);
         end
         clk_edge();
         hold0 = REQ0 && (mg != 0);
         hold1 = REQ1 && (mg != 1);
      end
      idle(); clk_edge(); clk_edge(); clk_edge();
   endtask

`ifdef DFFRAM_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      drive(1, 0, 9'd1, 0, 1, 0, 9'd2, 0); clk_edge();   // contention -> port 0
      drive(1, 0, 9'd3, 0, 1, 0, 9'd2, 0); clk_edge();   // contention -> port 1
      drive(1, 0, 9'd4, 0, 0, 0, 0, 0);    clk_edge();
      drive(0, 0, 0, 0, 1, 0, 9'd5, 0);    clk_edge();
      drive(1, 0, 9'd6, 0, 0, 0, 0, 0);    clk_edge();
      idle();
      @(negedge CLK);
      tests++; if (GCNT0 !== 16'd3 || GCNT1 !== 16'd2 || CCNT !== 16'd2) begin fails++; $display("FAIL stats_counts got %0d %0d %0d want 3 2 2", GCNT0, GCNT1, CCNT); end
      clk_edge();
      drive(1, 4'hF, 9'd7, 0, 0, 0, 0, 0);
      for (int k = 0; k < 70000; k++) clk_edge();
      idle();
      @(negedge CLK);
      tests++; if (GCNT0 !== 16'hFFFF || GCNT1 !== 16'd2 || CCNT !== 16'd2) begin fails++; $display("FAIL stats_saturate got %h %0d %0d want ffff 2 2", GCNT0, GCNT1, CCNT); end
      clk_edge();
   endtask
`endif

   initial begin
      cyc = 0;
      RESETn = 1'b0;
      idle();
      model_reset();
      for (int i = 0; i < 512; i++) begin
         ram[i]   = $urandom;
         mem_m[i] = ram[i];
      end
      test_reset();
      test_write_read();
      test_contention();
      test_byte_lanes();
      test_pipelined();
      test_reset_mid_read();
      test_random();
`ifdef DFFRAM_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
